// File: rtl/ascon_ct_streamer_if.sv
// Output stream of the ASCON ciphertext/tag streamer: 32-bit word with byte keep,
// tag/last framing and a valid/ready handshake.
interface ascon_ct_streamer_if;
    logic [31:0] out_data;
    logic [3:0]  out_keep;
    logic        out_tag;
    logic        out_last;
    logic        out_valid;
    logic        out_ready;

    modport master (
        output out_data, out_keep, out_tag, out_last, out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data, out_keep, out_tag, out_last, out_valid,
        output out_ready
    );
endinterface

// File: rtl/ascon_ct_streamer.sv
// Buffers 64-bit ASCON output blocks and the 128-bit tag, and re-emits them as a
// 32-bit valid/ready stream with byte keep, tag marking and end-of-message framing.
//
// state | meaning
// IDLE  | output slot empty, waiting for a block or a pending tag
// W0    | slot holds word 0 (bytes 0..3) of the FIFO head block
// W1    | slot holds word 1 (bytes 4..7) of the FIFO head block
// TAG   | slot holds tag word tc (0..3); word 3 carries out_last
module ascon_ct_streamer #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     nRST,
    input  logic [63:0]              CTblock,
    input  logic [3:0]               CTlen,
    input  logic                     CTv,
    input  logic [127:0]             Tag,
    input  logic                     Tv,
    input  logic                     clear,
    ascon_ct_streamer_if.master      strm,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic                     busy
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    typedef enum logic [1:0] {IDLE, W0, W1, TAG} state_t;

    logic [63:0]   mem_data [DEPTH];
    logic [3:0]    mem_len  [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr, nxt_ptr;
    logic [127:0]  tag_reg;
    logic          tag_pend;
    state_t        state;
    logic [1:0]    tc;
    logic [31:0]   data_q, tag_nxt;
    logic [3:0]    keep_q, head_len, nxt_len, clen;
    logic          tag_q, last_q, valid_q;
    logic          ct_hit, push, accept, can_adv, pop, tag_done;
    logic [LW-1:0] avail;
    logic [63:0]   nxt_data;

    function automatic logic [3:0] keep_of(input logic [3:0] n);
        return (n >= 4'd4) ? 4'hF : ~(4'hF >> n);
    endfunction

    assign clen     = (CTlen > 4'd8) ? 4'd8 : CTlen;
    assign ct_hit   = CTv & (CTlen != 4'd0);
    assign push     = ct_hit & (level < LW'(DEPTH)) & ~clear;
    assign accept   = valid_q & strm.out_ready;
    assign can_adv  = ~valid_q | strm.out_ready;
    assign head_len = mem_len[rd_ptr];
    assign pop      = accept & (((state == W0) & (head_len <= 4'd4)) | (state == W1));
    assign tag_done = accept & (state == TAG) & (tc == 2'd3);
    // Head after this edge's pop; lets the slot reload without a bubble.
    assign nxt_ptr  = rd_ptr + PW'(pop);
    assign avail    = level - LW'(pop);
    assign nxt_data = mem_data[nxt_ptr];
    assign nxt_len  = mem_len[nxt_ptr];

    always_comb begin
        tag_nxt = tag_reg[31:0];
        unique case (tc)
            2'd0:    tag_nxt = tag_reg[95:64];
            2'd1:    tag_nxt = tag_reg[63:32];
            default: tag_nxt = tag_reg[31:0];
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr] <= CTblock;
            mem_len[wr_ptr]  <= clen;
        end
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            rd_ptr <= nxt_ptr;
            level  <= level + LW'(push) - LW'(pop);
        end
    end

    // A tag arriving while one is still pending is dropped, never queued.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            tag_reg  <= '0;
            tag_pend <= 1'b0;
        end else if (clear || tag_done) begin
            tag_pend <= 1'b0;
        end else if (Tv && !tag_pend) begin
            tag_reg  <= Tag;
            tag_pend <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST)
            overflow <= 1'b0;
        else if (clear)
            overflow <= 1'b0;
        else if ((ct_hit && level == LW'(DEPTH)) || (Tv && tag_pend))
            overflow <= 1'b1;
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state   <= IDLE;
            tc      <= 2'd0;
            data_q  <= '0;
            keep_q  <= '0;
            tag_q   <= 1'b0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
        end else if (clear) begin
            state   <= IDLE;
            tc      <= 2'd0;
            data_q  <= '0;
            keep_q  <= '0;
            tag_q   <= 1'b0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
        end else if (can_adv) begin
            if (state == W0 && head_len > 4'd4) begin
                data_q <= mem_data[rd_ptr][31:0];
                keep_q <= keep_of(head_len - 4'd4);
                state  <= W1;
            end else if (state == TAG && tc != 2'd3) begin
                tc     <= tc + 2'd1;
                data_q <= tag_nxt;
                last_q <= (tc == 2'd2);
            end else if (avail != '0) begin
                data_q  <= nxt_data[63:32];
                keep_q  <= keep_of(nxt_len);
                tag_q   <= 1'b0;
                last_q  <= 1'b0;
                valid_q <= 1'b1;
                state   <= W0;
            // A block landing this edge must go out ahead of the pending tag.
            end else if (tag_pend && !push && state != TAG) begin
                data_q  <= tag_reg[127:96];
                keep_q  <= 4'hF;
                tag_q   <= 1'b1;
                last_q  <= 1'b0;
                valid_q <= 1'b1;
                tc      <= 2'd0;
                state   <= TAG;
            end else begin
                data_q  <= '0;
                keep_q  <= '0;
                tag_q   <= 1'b0;
                last_q  <= 1'b0;
                valid_q <= 1'b0;
                state   <= IDLE;
            end
        end
    end

    assign strm.out_data  = data_q;
    assign strm.out_keep  = keep_q;
    assign strm.out_tag   = tag_q;
    assign strm.out_last  = last_q;
    assign strm.out_valid = valid_q;
    assign busy = (level != '0) | tag_pend | valid_q;
endmodule

// File: doc/ascon_ct_streamer.md
# ascon_ct_streamer

Output stage placed directly downstream of the ASCON AEAD core. It captures each 64-bit ciphertext/plaintext block (`CTblock`/`CTv`) and the 128-bit tag (`Tag`/`Tv`) as the core produces them, and buffers blocks in a small FIFO. It re-emits everything as a 32-bit valid/ready byte stream with byte-keep, tag marking and end-of-message framing. This decouples the core's one-cycle strobes from a slow consumer such as a DMA or a Wishbone read path.

## Interface
- `DEPTH`, default 4: FIFO capacity in 64-bit blocks; power of two, 2..16.
- `clk`  in  1  clock.
- `nRST`  in  1  asynchronous active-low reset.
- `CTblock`  in  64  block from core; byte 0 is `[63:56]`.
- `CTlen`  in  4  valid bytes in `CTblock`, 0..8; byte 0 first.
- `CTv`  in  1  one-cycle strobe, block valid.
- `Tag`  in  128  tag from core; byte 0 is `[127:120]`.
- `Tv`  in  1  one-cycle strobe, tag valid.
- `clear`  in  1  synchronous flush of FIFO, tag, FSM and `overflow`.
- `out_data`  out  32  stream word; byte 0 is `[31:24]`.
- `out_keep`  out  4  byte enables; `out_keep[3]` qualifies `out_data[31:24]`.
- `out_tag`  out  1  current word is a tag word.
- `out_last`  out  1  final word of message (tag word 3).
- `out_valid`  out  1  word valid.
- `out_ready`  in  1  consumer accepts the word.
- `level`  out  $clog2(DEPTH)+1  FIFO occupancy in blocks.
- `overflow`  out  1  sticky; a block or tag was dropped.
- `busy`  out  1  FIFO non-empty, tag pending, or `out_valid` high.

## Operation
- **Push rules**
  - `CTv` with `CTlen`=0: ignored.
  - `CTv` with `CTlen` 1..8: `{CTblock, CTlen}` is written to the FIFO when `level`<`DEPTH` at that edge. Otherwise the block is dropped and `overflow` is set. A pop on the same edge does not rescue the push.
  - `CTlen`>8: treated as 8.
- **Tag capture**
  - `Tv`: `Tag` is latched and `tag_pend` is set.
  - `Tv` while `tag_pend` is already set: the new tag is dropped and `overflow` is set.
- **FSM states:** IDLE, W0, W1, TAG. The FSM loads a registered output slot. It advances only when the slot is empty or is being accepted (`out_valid & out_ready`).
  - **IDLE**
    - FIFO non-empty: load word 0, go to W0.
    - Else, if `tag_pend`: load tag word 0, go to TAG with tag counter `tc`=0.
  - **W0** (head block, len L)
    - Word 0 is `CTblock[63:32]`; `out_keep` = leading min(L,4) ones, e.g. L=2 gives 4'b1100.
    - L>4: next load is word 1 (`[31:0]`, keep = leading L−4 ones), go to W1.
    - L≤4: pop the FIFO when word 0 is accepted. Next action is as in IDLE.
  - **W1**: pop the FIFO on acceptance of word 1, then proceed as in IDLE.
  - **TAG**
    - Emits `Tag[127-32*tc -: 32]` with keep 4'b1111 and `out_tag`=1.
    - `out_last`=1 when `tc`=3.
    - On acceptance of word 3: clear `tag_pend`, go to IDLE.
- **Ordering:** the tag is emitted only after all blocks written before or on the same edge as `Tv` have been emitted. A block arriving after `Tv` but before the tag starts is emitted first.
- **`clear`**
  - Empties the FIFO, clears `tag_pend`, `overflow` and `out_valid`, and forces IDLE.
  - A `CTv`/`Tv` on the same edge is discarded.

## Timing
- **Reset values:** `out_data` 0, `out_keep` 0, `out_tag` 0, `out_last` 0, `out_valid` 0, `level` 0, `overflow` 0, `busy` 0; FSM in IDLE.
- **Latency:** `CTv` sampled at edge k into an empty block with idle output gives `out_valid`=1 after edge k+1.
- **Stability:** while `out_valid & ~out_ready`, all `out_*` are held stable.
- **Throughput:** one word per cycle with `out_ready` held high. There are no bubbles between words, blocks or tag words while data is available.
- **`level`:** updates on the edge after the push/pop; push and pop on the same edge leave it unchanged.
- **`busy`:** combinational from registered state.
- **Reset mid-stream:** all state is lost immediately; no partial message is resumed.

## Test plan
- **Single block:** `CTv` with `CTblock`=64'h0011223344556677, `CTlen`=8, `out_ready`=1 → words 32'h00112233 (keep F) then 32'h44556677 (keep F) on consecutive cycles, `out_valid` first high after edge k+1, `level` back to 0.
- **Partial blocks:** `CTlen`=3 → one word, keep 4'b1110. `CTlen`=6 → keep 4'b1111 then 4'b1100.
- **Tag framing:** block (`CTlen`=8) and `Tv` with `Tag`=128'h000102…0F on the same cycle → 2 data words, then tag words 00010203, 04050607, 08090A0B, 0C0D0E0F with `out_tag`=1; `out_last` only on the last.
- **Backpressure:** `out_ready`=0 with DEPTH=4 and 5 `CTv` pulses → `level`=4, `overflow`=1, 5th block never emitted. Random `out_ready` afterwards → first 4 blocks emitted intact, outputs stable while stalled.
- **Double tag:** second `Tv` before tag word 3 is accepted → `overflow`=1; only the first tag is emitted.
- **Clear and reset mid-stream:** `clear` during TAG word 1 → `out_valid`=0 next cycle, `busy`=0, `overflow`=0. `nRST` low during W1 → all outputs 0 immediately.
